// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and flag bit positions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_MUL  = 5'd6;
    localparam logic [4:0] OP_DIV  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_NAND = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_CMP  = 5'd12;
    localparam logic [4:0] OP_NOT  = 5'd13;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_DBZ     = 3;
    localparam int FLAG_ILLEGAL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Valid/ready operand and result channels of the multi-cycle ALU.
interface alu_multicycle_if #(
    parameter int WIDTH_DATA = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH_DATA-1:0] operand_a;
    logic [WIDTH_DATA-1:0] operand_b;
    logic [4:0]            op_code;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH_DATA-1:0] result;
    logic [4:0]            flags;

    modport master (
        output in_valid, operand_a, operand_b, op_code, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, operand_a, operand_b, op_code, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_seq #(
    parameter int WIDTH_DATA = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [WIDTH_DATA-1:0] operand_a,
    input  logic [WIDTH_DATA-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH_DATA-1:0] res_hi,
    output logic [WIDTH_DATA-1:0] res_lo
);
    localparam int W  = WIDTH_DATA;
    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0] cnt;
    logic          div_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W:0]    mul_sum;
    logic [W:0]    rem_sh;
    logic [W:0]    rem_diff;

    // MUL: hi:lo is the partial product with the multiplier shifting out of lo.
    // DIV: hi is the remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? b_q : {W{1'b0}})};
        rem_sh   = {hi, lo[W-1]};
        rem_diff = rem_sh - {1'b0, b_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= 1'b0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt   <= '0;
                div_q <= is_div;
                b_q   <= operand_b;
                hi    <= '0;
                lo    <= operand_a;
                busy  <= 1'b1;
            end else if (busy) begin
                if (div_q) begin
                    if (!rem_diff[W]) begin
                        hi <= rem_diff[W-1:0];
                        lo <= {lo[W-2:0], 1'b1};
                    end else begin
                        hi <= rem_sh[W-1:0];
                        lo <= {lo[W-2:0], 1'b0};
                    end
                end else begin
                    {hi, lo} <= {mul_sum, lo[W-1:1]};
                end
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign res_hi = hi;
    assign res_lo = lo;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU with registered result/flags; MUL/DIV are iterative and only
// built when ALU_MULDIV_EN is defined (otherwise opcodes 6 and 7 are illegal).
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// EXEC  | computing; single-cycle ops leave after one cycle
// DONE  | out_valid high, result/flags held until out_ready
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA = 32
) (
    input logic             clk,
    input logic             rst,
    alu_multicycle_if.slave bus
);
    localparam int W = WIDTH_DATA;

    state_t       state;
    logic [4:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] result_q;
    logic [4:0]   flags_q;
    logic         out_valid_q;
    logic [W-1:0] res_c;
    logic [4:0]   flg_c;
    logic         exec_last;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

`ifdef ALU_MULDIV_EN
    logic         seq_start;
    logic         seq_busy;
    logic         seq_done;
    logic [W-1:0] seq_hi;
    logic [W-1:0] seq_lo;
    logic         uses_seq;

    // The sequencer loads straight off the bus on the accept edge; divide by zero never starts it.
    assign seq_start = (state == IDLE) && bus.in_valid && is_muldiv(bus.op_code)
                       && !(bus.op_code == OP_DIV && bus.operand_b == '0);
    assign uses_seq  = is_muldiv(op_q) && !(op_q == OP_DIV && b_q == '0);
    assign exec_last = uses_seq ? (seq_done && !seq_busy) : 1'b1;

    alu_muldiv_seq #(.WIDTH_DATA(W)) u_muldiv_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (seq_start),
        .is_div    (bus.op_code == OP_DIV),
        .operand_a (bus.operand_a),
        .operand_b (bus.operand_b),
        .busy      (seq_busy),
        .done      (seq_done),
        .res_hi    (seq_hi),
        .res_lo    (seq_lo)
    );
`else
    assign exec_last = 1'b1;
`endif

    always_comb begin
        res_c = '0;
        flg_c = '0;
        case (op_q)
            OP_ADD:  {flg_c[FLAG_CARRY], res_c} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                res_c             = a_q - b_q;
                flg_c[FLAG_CARRY] = (a_q < b_q);
            end
            OP_AND:  res_c = a_q & b_q;
            OP_NAND: res_c = ~(a_q & b_q);
            OP_OR:   res_c = a_q | b_q;
            OP_NOT:  res_c = ~a_q;
            OP_CMP:  res_c = (a_q == b_q) ? '0 : ((a_q < b_q) ? W'(1) : W'(2));
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                res_c           = seq_lo;
                flg_c[FLAG_OVF] = |seq_hi;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_c           = '1;
                    flg_c[FLAG_DBZ] = 1'b1;
                end else begin
                    res_c = seq_lo;
                end
            end
`endif
            default: flg_c[FLAG_ILLEGAL] = 1'b1;
        endcase
        flg_c[FLAG_ZERO] = (res_c == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op_code;
                        a_q   <= bus.operand_a;
                        b_q   <= bus.operand_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        result_q    <= res_c;
                        flags_q     <= flg_c;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked successor to the combinational processor ALU. It keeps the same 5-bit opcode map and adds registered outputs, status flags and iterative multi-cycle MUL/DIV. Valid/ready on both sides lets the datapath stall on long operations. It sits between the register-file read stage and write-back.

## Interface
- WIDTH_DATA, 32, operand/result width; must be at least 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block accepts an operation; high only in IDLE.
- operand_a  in  WIDTH_DATA  first operand, unsigned.
- operand_b  in  WIDTH_DATA  second operand, unsigned.
- op_code  in  5  4 ADD, 5 SUB, 6 MUL, 7 DIV, 8 AND, 9 NAND, 10 OR, 12 CMP, 13 NOT; all other codes are illegal.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH_DATA  registered result.
- flags  out  5  {illegal, div_by_zero, overflow, carry, zero}.

## Operation
- Operations are accepted on a cycle where in_valid and in_ready are both high. Operands and opcode are latched into internal registers at that edge.
- ADD: result = a+b mod 2^W; carry = carry-out.
- SUB: result = a−b mod 2^W; carry = borrow (a<b).
- AND, OR: bitwise. NAND = ~(a&b). NOT = ~a; operand_b is ignored.
- CMP: result = 0 if a==b, 1 if a<b, 2 if a>b (unsigned).
- MUL: shift-add, one bit per cycle. result = low W bits of the product; overflow = high W bits nonzero.
- DIV: restoring division, one bit per cycle. result = quotient.
- DIV with b==0: no iteration. result = all-ones, div_by_zero=1.
- Illegal opcode: result=0, illegal=1.
- zero flag is set iff result==0, for every opcode including illegal.
- Flags not defined for an operation are 0.
- States:
  - IDLE: in_ready=1. Accept → EXEC.
  - EXEC: single-cycle ops, DIV-by-zero and illegal codes go to DONE on the next edge. MUL/DIV iterate a $clog2(WIDTH_DATA)+1-bit counter from 0 to WIDTH_DATA−1, then go to DONE.
  - DONE: out_valid=1; result and flags are held stable. out_ready=1 → IDLE.
- in_valid is ignored outside IDLE. Inputs may change freely after acceptance.

## Timing
- Reset values: state IDLE, in_ready=0 while rst is high and 1 after release, out_valid=0, result=0, flags=0, counter=0.
- Latency from accept edge to out_valid high:
  - 2 cycles for single-cycle ops, illegal codes and DIV-by-zero.
  - WIDTH_DATA+2 cycles for MUL/DIV.
- Throughput: one operation per 3 cycles minimum. No overlap; in_ready is low in EXEC and DONE.
- Result is held indefinitely while out_ready=0. A DONE→IDLE edge and the next accept cannot share a cycle.
- Reset asserted mid-EXEC or mid-DONE aborts the operation immediately. The pending result is discarded, with no spurious out_valid.
- out_ready asserted outside DONE has no effect.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIV use the iterative unit as specified.
- ALU_MULDIV_EN undefined:
  - No MUL/DIV hardware is built.
  - Opcodes 6 and 7 behave as illegal: result=0, illegal=1, zero=1, 2-cycle latency.
  - The counter is removed.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADD=4 … OP_NOT=13);
  - the state enum (IDLE, EXEC, DONE);
  - flag bit indices (FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2, FLAG_DBZ=3, FLAG_ILLEGAL=4).
- Sub-module alu_muldiv_seq:
  - start/busy/done interface, parametrised by WIDTH_DATA;
  - holds the counter, partial-product/remainder registers and the shift datapath;
  - instantiated only under ALU_MULDIV_EN.
- The top module holds the FSM, the combinational single-cycle ops and the output registers.

## Test plan
- ADD 10+20, out_ready=1 → out_valid 2 cycles after accept, result=30, flags=0. SUB 30−20 → 10. SUB 20−30 → 0xFFFFFFF6, carry=1.
- MUL 3×4 → result=12 at WIDTH_DATA+2=34 cycles. MUL 0x10000×0x10000 → result=0, overflow=1, zero=1.
- DIV 40/4 → 10 at 34 cycles. DIV 7/0 → 0xFFFFFFFF, div_by_zero=1, at 2 cycles.
- Logic and compare ops:
  - AND 1,0 → 0, zero=1. NAND 1,0 → 0xFFFFFFFF. OR 1,1 → 1. NOT 1 → 0xFFFFFFFE.
  - CMP 10,10 → 0. CMP 3,9 → 1. CMP 9,3 → 2.
  - opcode 11 → result=0, illegal=1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD → result stable, in_ready=0, and an in_valid pulse is not accepted. Release → IDLE next cycle.
- Assert rst at cycle 10 of a MUL → out_valid never rises. After release, ADD 1+1 → 2. Repeat the MUL and DIV checks with WIDTH_DATA=8 and with ALU_MULDIV_EN undefined (MUL → illegal=1).
